// File: rtl/keypad_if.sv
// Keypad decoder bundle: raw key lines in, debounced key events out.
interface keypad_if;
  logic [9:0] keypad;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_repeat;
  logic       key_held;
  logic       multi_key;

  // master drives the raw lines and consumes events; slave is the decoder
  modport master (output keypad,
                  input  key_valid, key_code, key_repeat, key_held, multi_key);
  modport slave  (input  keypad,
                  output key_valid, key_code, key_repeat, key_held, multi_key);
endinterface

// File: rtl/keypad_decoder.sv
// 10-key keypad front end: 2-flop sync, press/release debounce, BCD encode,
// optional auto-repeat and multi-key flag. All outputs registered.
module keypad_decoder #(
  parameter int unsigned DEB_CYCLES    = 20,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);

  localparam int unsigned NKEYS  = 10;
  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t              state;
  logic [NKEYS-1:0]    sync1, sync2, capture;
  logic [CNT_W-1:0]    cnt;
  logic [RCNT_W-1:0]   rcnt;
  logic                rep_first;

  function automatic logic [3:0] encode(input logic [NKEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NKEYS); i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      capture       <= '0;
      cnt           <= '0;
      rcnt          <= '0;
      rep_first     <= 1'b1;
      state         <= IDLE;
      kp.key_valid  <= 1'b0;
      kp.key_code   <= '0;
      kp.key_repeat <= 1'b0;
      kp.key_held   <= 1'b0;
      kp.multi_key  <= 1'b0;
    end else begin
      sync1         <= kp.keypad;
      sync2         <= sync1;
      kp.key_valid  <= 1'b0;
      kp.key_repeat <= 1'b0;
      kp.multi_key  <= 1'b0;

      case (state)
        IDLE: begin
          kp.key_held  <= 1'b0;
          kp.multi_key <= ($countones(sync2) > 1);
          if ($onehot(sync2)) begin
            capture <= sync2;
            cnt     <= CNT_W'(1);
            state   <= DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (sync2 == capture) begin
            if (cnt == DEB_LAST) begin
              kp.key_valid <= 1'b1;
              kp.key_code  <= encode(capture);
              kp.key_held  <= 1'b1;
              rcnt         <= '0;
              rep_first    <= 1'b1;
              state        <= HELD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
          end
        end

        // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
        HELD: begin
          if (sync2 == capture) begin
            if (REPEAT_EN) begin
              if (rcnt == (rep_first ? DELAY_LAST : PERIOD_LAST)) begin
                kp.key_valid  <= 1'b1;
                kp.key_repeat <= 1'b1;
                rcnt          <= '0;
                rep_first     <= 1'b0;
              end else begin
                rcnt <= rcnt + RCNT_W'(1);
              end
            end
          end else begin
            kp.key_held <= 1'b0;
            cnt         <= '0;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          if (sync2 == '0) begin
            if (cnt == DEB_LAST) state <= IDLE;
            else                 cnt   <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Input-side counterpart to the display path. Receives the raw 10-key keypad lines (digit keys 0-9) and runs on the 1 kHz system clock.
- Synchronises, debounces and encodes the lines into single-cycle key events with a BCD code.
- Provides optional auto-repeat and a multi-key error flag.
- Feeds watch/stopwatch/alarm setting logic, which consume events instead of raw levels.

Parameters:
- DEB_CYCLES, 20, consecutive stable synced samples required to accept a press or a release (20 ms at 1 kHz); legal range 2..255.
- REPEAT_EN, 1, 1 = generate auto-repeat events while a key is held.
- REPEAT_DELAY, 500, cycles from the accept pulse to the first repeat pulse; legal range 2..1023.
- REPEAT_PERIOD, 100, cycles between subsequent repeat pulses; legal range 2..1023.

Ports:
- clk  in  1  system clock, 1 kHz
- rst  in  1  synchronous reset, active-high
- keypad  in  10  raw key lines, active-high, bit i = digit i, asynchronous to clk
- key_valid  out  1  one-cycle event strobe (press or repeat)
- key_code  out  4  BCD digit 0-9 of the last accepted key; valid with key_valid and held after it
- key_repeat  out  1  high together with key_valid when the event is an auto-repeat
- key_held  out  1  level, high while the accepted key remains pressed (HELD state)
- multi_key  out  1  level, high while the FSM is in IDLE and more than one synced bit is set

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clk. It clears the sync flops, all counters and the FSM to IDLE.
- Output reset values: key_valid=0, key_code=0, key_repeat=0, key_held=0, multi_key=0.
- Synchroniser: 2 flops per bit. The FSM sees a raw change at the second edge after it occurs. All outputs are registered.
- IDLE:
  - synced vector one-hot → capture vector, cnt=1, go to DEBOUNCE.
  - more than one bit set → multi_key=1, stay in IDLE.
  - zero → stay in IDLE.
- DEBOUNCE:
  - vector equals the capture → cnt++.
  - when cnt reaches DEB_CYCLES → pulse key_valid for 1 cycle, load key_code = index of the set bit, key_repeat=0, go to HELD with rcnt=0.
  - any mismatch (bounce, release, second key) → go to IDLE with no event.
- Press latency: raw key first sampled at edge 0 → key_valid high in the cycle after edge DEB_CYCLES+1 (edge 21 for defaults).
- HELD:
  - key_held=1.
  - vector equals the capture and REPEAT_EN=1 → rcnt++. A repeat pulse (key_valid=1, key_repeat=1, same key_code) fires when rcnt hits REPEAT_DELAY for the first repeat and REPEAT_PERIOD for later repeats. rcnt restarts from 0 after each pulse.
  - REPEAT_EN=0 → no repeats.
  - any mismatch (release or an additional key) → go to RELEASE, cnt=0, key_held=0 on the next cycle, no event.
- RELEASE:
  - vector all-zero → cnt++.
  - any nonzero sample → cnt=0, stay in RELEASE.
  - cnt reaches DEB_CYCLES → go to IDLE.
  - No new key can be accepted before the release completes; rollover to a second key requires a full release first.
- key_code holds its value across HELD/RELEASE/IDLE and changes only on an accept pulse.
- key_valid is never high on two consecutive cycles.
- Counter widths are sized to their parameter range; no wrap is possible because every counter is compared and cleared before overflow.
- Reset asserted mid-press → everything clears. If the key is still held after reset deasserts, it is re-debounced from IDLE and produces one new press event.

Test Plan:
- Clean press: keypad=10'b00_0010_0000 from edge 0, held 50 cycles, then 0 → one key_valid at edge 21 with key_code=5 and key_repeat=0. key_held is high until the mismatch is seen; the FSM is back in IDLE DEB_CYCLES cycles after the synced release.
- Bounce: bit3 toggles high/low every 3 cycles for 15 cycles, then stays high → no event during the bounce; a single key_valid with key_code=3 occurs DEB_CYCLES+1 edges after the last rising transition.
- Auto-repeat: hold key 7 for 900 cycles with defaults → pulses at edges 21 (key_repeat=0), 521, 621, 721 and 821 (key_repeat=1), all with key_code=7. Rerun with REPEAT_EN=0 → only the edge-21 pulse.
- Multi-key: keypad=10'b00_0000_0011 → multi_key=1 from edge 2 and no key_valid. Drop bit0 → multi_key=0, then one event with key_code=1.
- Rollover: hold 2, then add 9 while still holding 2, then release 2 → no event for 9 until the full release. Release all, press 9 → an event with key_code=9.
- Reset mid-hold: hold key 4, assert rst for 1 cycle at edge 100 → all outputs 0 on the next cycle. Key still held → a new key_valid with key_code=4 arrives DEB_CYCLES+1 edges after rst deasserts.
